// File: rtl/apb_master.sv
// APB master: accepts one command at a time through a valid/ready handshake,
// runs a single APB transfer (SETUP then ACCESS), and reports completion with
// a one-cycle response pulse. ACCESS is abandoned after TIMEOUT_CYCLES wait
// cycles and the response is flagged as a timeout error.
module apb_master #(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_rsp_timeout,
    output logic                  o_psel,
    output logic                  o_penable,
    output logic                  o_pwrite,
    output logic [ADDR_WIDTH-1:0] o_paddr,
    output logic [DATA_WIDTH-1:0] o_pwdata,
    input  logic                  i_pready,
    input  logic                  i_pslverr,
    input  logic [DATA_WIDTH-1:0] i_prdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t                r_state,       w_state_nx;
    logic                  r_cmd_ready,   w_cmd_ready_nx;
    logic                  r_psel,        w_psel_nx;
    logic                  r_penable,     w_penable_nx;
    logic                  r_pwrite,      w_pwrite_nx;
    logic [ADDR_WIDTH-1:0] r_paddr,       w_paddr_nx;
    logic [DATA_WIDTH-1:0] r_pwdata,      w_pwdata_nx;
    logic                  r_rsp_valid,   w_rsp_valid_nx;
    logic [DATA_WIDTH-1:0] r_rsp_rdata,   w_rsp_rdata_nx;
    logic                  r_rsp_err,     w_rsp_err_nx;
    logic                  r_rsp_timeout, w_rsp_timeout_nx;
    logic [CNT_W-1:0]      r_cnt,         w_cnt_nx;

    // Next-state and next-output logic; every output is a register so the
    // APB and response pins never glitch on completer inputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned, which would infer a latch.
        w_state_nx       = r_state;
        w_cmd_ready_nx   = r_cmd_ready;
        w_psel_nx        = r_psel;
        w_penable_nx     = r_penable;
        w_pwrite_nx      = r_pwrite;
        w_paddr_nx       = r_paddr;
        w_pwdata_nx      = r_pwdata;
        w_rsp_valid_nx   = 1'b0;
        w_rsp_rdata_nx   = r_rsp_rdata;
        w_rsp_err_nx     = 1'b0;
        w_rsp_timeout_nx = 1'b0;
        w_cnt_nx         = r_cnt;

        case (r_state)
            ST_IDLE: begin
                // Ready rises one edge after reset release and stays up in IDLE.
                w_cmd_ready_nx = 1'b1;
                if (i_cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_nx = 1'b0;
                    w_pwrite_nx    = i_cmd_write;
                    w_paddr_nx     = i_cmd_addr;
                    w_pwdata_nx    = i_cmd_wdata;
                    w_psel_nx      = 1'b1;
                    w_penable_nx   = 1'b0;
                    w_state_nx     = ST_SETUP;
                end
            end

            ST_SETUP: begin
                w_penable_nx = 1'b1;
                w_cnt_nx     = '0;
                w_state_nx   = ST_ACCESS;
            end

            ST_ACCESS: begin
                // A ready completer wins even on the edge the timeout would fire.
                if (i_pready) begin
                    w_state_nx     = ST_IDLE;
                    w_cmd_ready_nx = 1'b1;
                    w_psel_nx      = 1'b0;
                    w_penable_nx   = 1'b0;
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_err_nx   = i_pslverr;
                    w_rsp_rdata_nx = r_pwrite ? '0 : i_prdata;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nx       = ST_IDLE;
                    w_cmd_ready_nx   = 1'b1;
                    w_psel_nx        = 1'b0;
                    w_penable_nx     = 1'b0;
                    w_rsp_valid_nx   = 1'b1;
                    w_rsp_err_nx     = 1'b1;
                    w_rsp_timeout_nx = 1'b1;
                    w_rsp_rdata_nx   = '0;
                    w_cnt_nx         = CNT_W'(TIMEOUT_CYCLES);
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nx     = ST_IDLE;
                w_cmd_ready_nx = 1'b0;
                w_psel_nx      = 1'b0;
                w_penable_nx   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer without a response.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state       <= w_state_nx;
            r_cmd_ready   <= w_cmd_ready_nx;
            r_psel        <= w_psel_nx;
            r_penable     <= w_penable_nx;
            r_pwrite      <= w_pwrite_nx;
            r_paddr       <= w_paddr_nx;
            r_pwdata      <= w_pwdata_nx;
            r_rsp_valid   <= w_rsp_valid_nx;
            r_rsp_rdata   <= w_rsp_rdata_nx;
            r_rsp_err     <= w_rsp_err_nx;
            r_rsp_timeout <= w_rsp_timeout_nx;
            r_cnt         <= w_cnt_nx;
        end
    end

    assign o_cmd_ready   = r_cmd_ready;
    assign o_psel        = r_psel;
    assign o_penable     = r_penable;
    assign o_pwrite      = r_pwrite;
    assign o_paddr       = r_paddr;
    assign o_pwdata      = r_pwdata;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master: the bench plays the APB completer, computes the
// expected response of each transaction from its wait count, error flag and
// read data, and checks pins cycle by cycle on the falling clock edge.
module tb_apb_master;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int T  = 15;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic          i_cmd_write;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_wdata;
    logic          o_rsp_valid;
    logic [DW-1:0] o_rsp_rdata;
    logic          o_rsp_err;
    logic          o_rsp_timeout;
    logic          o_psel;
    logic          o_penable;
    logic          o_pwrite;
    logic [AW-1:0] o_paddr;
    logic [DW-1:0] o_pwdata;
    logic          i_pready;
    logic          i_pslverr;
    logic [DW-1:0] i_prdata;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] last_rdata;

    always #5 i_clk = ~i_clk;

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_write  (i_cmd_write),
        .i_cmd_addr   (i_cmd_addr),
        .i_cmd_wdata  (i_cmd_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err),
        .o_rsp_timeout(o_rsp_timeout),
        .o_psel       (o_psel),
        .o_penable    (o_penable),
        .o_pwrite     (o_pwrite),
        .o_paddr      (o_paddr),
        .o_pwdata     (o_pwdata),
        .i_pready     (i_pready),
        .i_pslverr    (i_pslverr),
        .i_prdata     (i_prdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic scramble_completer();
        i_pready  = 1'($urandom);
        i_pslverr = 1'($urandom);
        i_prdata  = DW'($urandom);
    endtask

    // One complete transaction. Called just after a falling edge; returns on
    // the falling edge of the response cycle so a following call can be
    // accepted back-to-back.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int waits,
                           input logic slverr, input logic [DW-1:0] prdata,
                           input bit hold_valid);
        int            n;
        int            acc;
        bit            to;
        logic [DW-1:0] exp_rd;
        // Completer holds off `waits` ACCESS cycles; T or more means timeout.
        to  = (waits >= T);
        acc = to ? T : waits + 1;
        i_cmd_valid = 1'b1;
        i_cmd_write = wr;
        i_cmd_addr  = addr;
        i_cmd_wdata = wdata;
        n = 0;
        while (o_cmd_ready !== 1'b1 && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        if (o_cmd_ready !== 1'b1) begin
            check("ready_wait", 32'(o_cmd_ready), 1);
            i_cmd_valid = 1'b0;
            return;
        end
        check("accept_only_idle_psel", 32'(o_psel), 0);

        @(negedge i_clk);
        if (!hold_valid) i_cmd_valid = 1'b0;
        i_cmd_write = 1'($urandom);
        i_cmd_addr  = AW'($urandom);
        i_cmd_wdata = DW'($urandom);
        check("setup_psel", 32'(o_psel), 1);
        check("setup_penable", 32'(o_penable), 0);
        check("setup_pwrite", 32'(o_pwrite), 32'(wr));
        check("setup_paddr", 32'(o_paddr), 32'(addr));
        check("setup_pwdata", 32'(o_pwdata), 32'(wdata));
        check("setup_ready", 32'(o_cmd_ready), 0);
        check("setup_rsp_valid", 32'(o_rsp_valid), 0);
        check("rdata_hold", 32'(o_rsp_rdata), 32'(last_rdata));
        scramble_completer();

        for (int k = 1; k <= acc; k++) begin
            @(negedge i_clk);
            check("access_psel", 32'(o_psel), 1);
            check("access_penable", 32'(o_penable), 1);
            check("access_paddr", 32'(o_paddr), 32'(addr));
            check("access_pwrite", 32'(o_pwrite), 32'(wr));
            check("access_pwdata", 32'(o_pwdata), 32'(wdata));
            check("access_rsp_valid", 32'(o_rsp_valid), 0);
            if (k == acc && !to) begin
                i_pready  = 1'b1;
                i_pslverr = slverr;
                i_prdata  = prdata;
            end else begin
                i_pready  = 1'b0;
                i_pslverr = 1'($urandom);
                i_prdata  = DW'($urandom);
            end
        end

        @(negedge i_clk);
        scramble_completer();
        exp_rd = (wr || to) ? '0 : prdata;
        check("rsp_valid", 32'(o_rsp_valid), 1);
        check("rsp_err", 32'(o_rsp_err), 32'(to || slverr));
        check("rsp_timeout", 32'(o_rsp_timeout), 32'(to));
        check("rsp_rdata", 32'(o_rsp_rdata), 32'(exp_rd));
        check("rsp_psel", 32'(o_psel), 0);
        check("rsp_penable", 32'(o_penable), 0);
        check("rsp_ready", 32'(o_cmd_ready), 1);
        last_rdata = exp_rd;
    endtask

    task automatic idle_cycle_checks();
        @(negedge i_clk);
        check("pulse_valid_low", 32'(o_rsp_valid), 0);
        check("pulse_err_low", 32'(o_rsp_err), 0);
        check("pulse_timeout_low", 32'(o_rsp_timeout), 0);
        check("rdata_hold_idle", 32'(o_rsp_rdata), 32'(last_rdata));
        check("idle_psel", 32'(o_psel), 0);
    endtask

    initial begin
        int r;
        int waits;
        i_rst       = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_write = 1'b0;
        i_cmd_addr  = '0;
        i_cmd_wdata = '0;
        i_pready    = 1'b0;
        i_pslverr   = 1'b0;
        i_prdata    = '0;
        last_rdata  = '0;

        #3;
        check("rst_ready", 32'(o_cmd_ready), 0);
        check("rst_psel", 32'(o_psel), 0);
        check("rst_penable", 32'(o_penable), 0);
        check("rst_pwrite", 32'(o_pwrite), 0);
        check("rst_paddr", 32'(o_paddr), 0);
        check("rst_pwdata", 32'(o_pwdata), 0);
        check("rst_rsp_valid", 32'(o_rsp_valid), 0);
        check("rst_rsp_rdata", 32'(o_rsp_rdata), 0);
        check("rst_rsp_err", 32'(o_rsp_err), 0);
        check("rst_rsp_timeout", 32'(o_rsp_timeout), 0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        check("ready_before_first_edge", 32'(o_cmd_ready), 0);
        @(negedge i_clk);
        check("ready_after_first_edge", 32'(o_cmd_ready), 1);

        // Directed: zero-wait write, waited read, slave error, timeout edges.
        run_txn(1'b1, 3'd3, 8'hA5, 0, 1'b0, 8'h00, 1'b0);
        idle_cycle_checks();
        run_txn(1'b0, 3'd5, 8'h00, 2, 1'b0, 8'h3C, 1'b0);
        idle_cycle_checks();
        run_txn(1'b0, 3'd1, 8'h00, 1, 1'b1, 8'h77, 1'b0);
        idle_cycle_checks();
        run_txn(1'b0, 3'd2, 8'h00, T, 1'b0, 8'h99, 1'b0);
        idle_cycle_checks();
        run_txn(1'b0, 3'd4, 8'h00, T - 1, 1'b0, 8'h5A, 1'b0);
        idle_cycle_checks();

        // Back-to-back commands with valid held high.
        for (int a = 0; a < 8; a++)
            run_txn(1'($urandom), AW'(a), DW'($urandom), a % 3, 1'b0, DW'(8'h10 + a), 1'b1);
        i_cmd_valid = 1'b0;
        idle_cycle_checks();

        // Reset in the middle of ACCESS aborts with no response.
        i_cmd_valid = 1'b1;
        i_cmd_write = 1'b0;
        i_cmd_addr  = 3'd6;
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        i_pready    = 1'b0;
        @(negedge i_clk);
        check("pre_rst_penable", 32'(o_penable), 1);
        #2 i_rst = 1'b1;
        #1;
        check("midrst_psel", 32'(o_psel), 0);
        check("midrst_penable", 32'(o_penable), 0);
        check("midrst_ready", 32'(o_cmd_ready), 0);
        check("midrst_paddr", 32'(o_paddr), 0);
        last_rdata = '0;
        repeat (2) begin
            @(negedge i_clk);
            check("midrst_no_rsp", 32'(o_rsp_valid), 0);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
        check("post_rst_no_rsp", 32'(o_rsp_valid), 0);
        check("post_rst_ready", 32'(o_cmd_ready), 1);
        run_txn(1'b0, 3'd7, 8'h00, 1, 1'b0, 8'hC3, 1'b0);
        idle_cycle_checks();

        // Randomized traffic, mostly short waits with some timeout corners.
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       waits = int'($urandom_range(0, 3));
            else if (r == 7) waits = T - 1;
            else if (r == 8) waits = T;
            else             waits = T + int'($urandom_range(0, 5));
            run_txn(1'($urandom), AW'($urandom), DW'($urandom), waits,
                    1'($urandom), DW'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 0) begin
                i_cmd_valid = 1'b0;
                idle_cycle_checks();
            end
        end
        i_cmd_valid = 1'b0;
        idle_cycle_checks();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 15, max ACCESS wait cycles (>=1).
REQ-004 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_cmd_valid  input  1  command request.
REQ-007 SHALL have port o_cmd_ready  output  1  command accepted when high with i_cmd_valid.
REQ-008 SHALL have port i_cmd_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port i_cmd_addr  input  ADDR_WIDTH  target register address.
REQ-010 SHALL have port i_cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port o_rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port o_rsp_rdata  output  DATA_WIDTH  read data, valid with o_rsp_valid.
REQ-013 SHALL have port o_rsp_err  output  1  completion error (PSLVERR or timeout).
REQ-014 SHALL have port o_rsp_timeout  output  1  completion terminated by timeout.
REQ-015 SHALL have ports o_psel, o_penable, o_pwrite  output  1 each  APB controls.
REQ-016 SHALL have ports o_paddr  output  ADDR_WIDTH and o_pwdata  output  DATA_WIDTH  APB address/data.
REQ-017 SHALL have ports i_pready, i_pslverr  input  1 each and i_prdata  input  DATA_WIDTH  APB completer response.

Function
REQ-018 SHALL implement FSM IDLE, SETUP, ACCESS; all outputs registered.
REQ-019 o_cmd_ready SHALL be 1 only in IDLE; handshake = i_cmd_valid & o_cmd_ready at a rising edge.
REQ-020 On handshake: latch write/addr/wdata into o_pwrite/o_paddr/o_pwdata, o_psel=1, o_penable=0, go SETUP.
REQ-021 SETUP SHALL last exactly one cycle, then ACCESS with o_penable=1; o_paddr/o_pwrite/o_pwdata stable throughout SETUP and ACCESS.
REQ-022 i_pready/i_prdata/i_pslverr SHALL be sampled only in ACCESS; ignored in IDLE/SETUP.
REQ-023 ACCESS with i_pready=1 at an edge: next cycle o_rsp_valid=1, o_rsp_err=i_pslverr, o_rsp_timeout=0, o_rsp_rdata=i_prdata for reads, 0 for writes; o_psel=o_penable=0; go IDLE.
REQ-024 Wait counter SHALL clear on SETUP->ACCESS, increment each ACCESS cycle with i_pready=0, saturating at TIMEOUT_CYCLES.
REQ-025 When counter reaches TIMEOUT_CYCLES with i_pready still 0: terminate as REQ-023 but o_rsp_err=1, o_rsp_timeout=1, o_rsp_rdata=0.
REQ-026 i_pready=1 on the same edge the counter would reach TIMEOUT_CYCLES SHALL complete normally (pready wins).
REQ-027 Zero-wait latency: handshake edge to o_rsp_valid high = 3 cycles; o_cmd_ready returns high with o_rsp_valid.
REQ-028 New command SHALL be accepted no earlier than the cycle o_rsp_valid is high; o_psel SHALL drop for at least one cycle between transfers.
REQ-029 o_rsp_valid/o_rsp_err/o_rsp_timeout SHALL be 1 for exactly one cycle; o_rsp_rdata holds until next completion.
REQ-030 i_cmd_* changes while not in IDLE SHALL not affect the transfer in progress.

Reset
REQ-031 i_rst=1 SHALL immediately force IDLE, o_psel=o_penable=o_pwrite=0, o_paddr=o_pwdata=0, o_rsp_*=0, counter=0, o_cmd_ready=0.
REQ-032 o_cmd_ready SHALL go 1 on the first rising edge after i_rst deasserts; reset mid-transfer SHALL abort it with no response pulse.

Verification
REQ-033 Write addr=3 data=0xA5, i_pready=1 -> SETUP psel=1/penable=0, ACCESS penable=1, paddr=3, pwdata=0xA5, pwrite=1; rsp_valid 3 cycles after handshake, err=0, rdata=0.
REQ-034 Read addr=5, i_pready low 2 ACCESS cycles then high with prdata=0x3C -> rsp_valid, rdata=0x3C, err=0; addr stable throughout.
REQ-035 Read with i_pslverr=1 at pready -> rsp_err=1, rsp_timeout=0.
REQ-036 i_pready held 0 -> after 15 ACCESS cycles rsp_valid=1, err=1, timeout=1, rdata=0, psel=0; pready=1 on 15th cycle -> normal completion.
REQ-037 i_rst asserted in ACCESS -> psel/penable 0 same cycle, no rsp_valid; next command after release completes normally.
REQ-038 i_cmd_valid held high with 8 back-to-back commands addr 0..7 -> each accepted only in IDLE, psel low >=1 cycle between, 8 responses in order.
